sram_seq: RTL and testbench



---
 rtl/sram_seq.sv | 271 +++++++++++++++++++++++++++
 tb/tb_sram_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_seq.sv
// rtl/sram_seq.sv - SRAM write/read-back test sequencer driving the I/O controller oen/wen handshake
//
// Purpose:
//   On an accepted start, writes count words of seed+i to base+i through the
//   active-low request handshake of the SRAM I/O controller. With
//   SRAM_SEQ_VERIFY_EN defined, the words are then read back and compared,
//   and mismatches are reported. Without it, the run ends after the writes
//   with pass=1, err_cnt=0 and first_err_addr tied to 0.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   start             - one-cycle request, accepted only in IDLE
//   base_addr, seed,
//   count             - run parameters, sampled when start is accepted
//   oen, wen          - active-low read/write requests to the I/O controller
//   data_in, addr     - write data and word address to the I/O controller
//   data_out, done    - read data and completion level from the I/O controller
//   busy, finished,
//   pass, err_cnt,
//   first_err_addr    - run status for board-level reporting
module sram_seq #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  oen,
  output logic                  wen,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  done,
  output logic                  busy,
  output logic                  finished,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

`ifdef SRAM_SEQ_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_REL = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_REL = 3'd4,
    S_FINISH = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_REL = 3'd2,
    S_FINISH = 3'd5
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic                  oen_q, oen_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  finished_q, finished_d;
  logic                  pass_q, pass_d;

  logic [CNT_WIDTH-1:0]  idx_inc;
  logic                  last_word;
  logic                  no_errors;

  assign idx_inc   = idx_q + CNT_WIDTH'(1);
  // Only evaluated outside IDLE, where cnt_q is known to be non-zero.
  assign last_word = (idx_q == (cnt_q - CNT_WIDTH'(1)));

`ifdef SRAM_SEQ_VERIFY_EN
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
  logic [DATA_WIDTH-1:0] expect_data;

  assign expect_data = seed_q + DATA_WIDTH'(idx_q);
  assign no_errors   = (err_cnt_q == '0);
`else
  logic unused_data_out;

  assign unused_data_out = ^data_out;
  assign no_errors       = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    oen_d      = oen_q;
    wen_d      = wen_q;
    data_in_d  = data_in_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    finished_d = finished_q;
    pass_d     = pass_q;
`ifdef SRAM_SEQ_VERIFY_EN
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          seed_d     = seed;
          cnt_d      = count;
          idx_d      = '0;
          finished_d = 1'b0;
          pass_d     = 1'b0;
          busy_d     = 1'b1;
`ifdef SRAM_SEQ_VERIFY_EN
          err_cnt_d        = '0;
          first_err_addr_d = '0;
`endif
          if (count == '0) begin
            state_d = S_FINISH;
          end else begin
            // Request is registered so it appears in the cycle after start.
            state_d   = S_WR_REQ;
            wen_d     = 1'b0;
            addr_d    = base_addr;
            data_in_d = seed;
          end
        end
      end

      S_WR_REQ: begin
        if (done) begin
          wen_d   = 1'b1;
          state_d = S_WR_REL;
        end
      end

      S_WR_REL: begin
        if (!done) begin
          if (last_word) begin
            idx_d = '0;
`ifdef SRAM_SEQ_VERIFY_EN
            state_d = S_RD_REQ;
            oen_d   = 1'b0;
            addr_d  = base_q;
`else
            state_d = S_FINISH;
`endif
          end else begin
            idx_d     = idx_inc;
            state_d   = S_WR_REQ;
            wen_d     = 1'b0;
            addr_d    = base_q + ADDR_WIDTH'(idx_inc);
            data_in_d = seed_q + DATA_WIDTH'(idx_inc);
          end
        end
      end

`ifdef SRAM_SEQ_VERIFY_EN
      S_RD_REQ: begin
        if (done) begin
          oen_d   = 1'b1;
          state_d = S_RD_REL;
          if (data_out != expect_data) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
            // addr_q still holds base+i for the word under test.
            if (err_cnt_q == '0) begin
              first_err_addr_d = addr_q;
            end
          end
        end
      end

      S_RD_REL: begin
        if (!done) begin
          if (last_word) begin
            idx_d   = '0;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_inc;
            state_d = S_RD_REQ;
            oen_d   = 1'b0;
            addr_d  = base_q + ADDR_WIDTH'(idx_inc);
          end
        end
      end
`endif

      S_FINISH: begin
        finished_d = 1'b1;
        busy_d     = 1'b0;
        pass_d     = no_errors;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      seed_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      oen_q      <= 1'b1;
      wen_q      <= 1'b1;
      data_in_q  <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      oen_q      <= oen_d;
      wen_q      <= wen_d;
      data_in_q  <= data_in_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      pass_q     <= pass_d;
    end
  end

`ifdef SRAM_SEQ_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
    end else begin
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;
`else
  assign err_cnt        = '0;
  assign first_err_addr = '0;
`endif

  assign oen      = oen_q;
  assign wen      = wen_q;
  assign data_in  = data_in_q;
  assign addr     = addr_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_sram_seq.sv
// tb/tb_sram_seq.sv - directed scoreboard bench for sram_seq with an I/O controller and SRAM model
module tb_sram_seq;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] seed;
  logic [CW-1:0] count;
  logic          oen;
  logic          wen;
  logic [DW-1:0] data_in;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out = '0;
  logic          done = 1'b0;
  logic          busy;
  logic          finished;
  logic          pass;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] first_err_addr;

  sram_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .seed(seed),
    .count(count), .oen(oen), .wen(wen), .data_in(data_in), .addr(addr),
    .data_out(data_out), .done(done), .busy(busy), .finished(finished),
    .pass(pass), .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_exp_t;

  wr_exp_t       wq[$];
  logic [AW-1:0] rq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] bad_addr = '0;
  int            t = 0;
  int            nwrites = 0;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // I/O controller + SRAM model: done rises 4 cycles into a request and
  // falls 2 cycles later, giving the 6-cycle word handshake.
  always @(negedge clk) begin
    if (rst) begin
      t    = 0;
      done = 1'b0;
    end else begin
      if (t == 0 && (!wen || !oen)) begin
        t        = 1;
        req_addr = addr;
        req_data = data_in;
      end else if (t != 0) begin
        t++;
      end
      if (t >= 2 && t <= 4) begin
        chk("addr_stable", 64'(addr), 64'(req_addr));
        if (!wen) chk("data_stable", 64'(data_in), 64'(req_data));
      end
      if (t == 4) begin
        chk("req_exclusive", 64'(wen | oen), 64'(1));
        if (!wen) begin
          if (wq.size() == 0) begin
            chk("wr_unexpected", 64'(1), 64'(0));
          end else begin
            wr_exp_t e;
            e = wq.pop_front();
            chk("wr_addr", 64'(addr), 64'(e.a));
            chk("wr_data", 64'(data_in), 64'(e.d));
          end
          mem[addr] = data_in;
          nwrites++;
        end else if (!oen) begin
          if (rq.size() == 0) begin
            chk("rd_unexpected", 64'(1), 64'(0));
          end else begin
            chk("rd_addr", 64'(addr), 64'(rq.pop_front()));
          end
          data_out = mem.exists(addr) ? mem[addr] : '0;
          if (corrupt_en && addr == bad_addr) data_out = data_out ^ 32'h0000_0100;
        end else begin
          chk("req_held", 64'(0), 64'(1));
        end
        done = 1'b1;
      end
      if (t == 6) begin
        t    = 0;
        done = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_oen"}, 64'(oen), 64'(1));
    chk({tag, "_wen"}, 64'(wen), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_finished"}, 64'(finished), 64'(0));
    chk({tag, "_pass"}, 64'(pass), 64'(0));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(0));
    chk({tag, "_addr"}, 64'(addr), 64'(0));
    chk({tag, "_data_in"}, 64'(data_in), 64'(0));
    chk({tag, "_first_err"}, 64'(first_err_addr), 64'(0));
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [DW-1:0] s, input logic [CW-1:0] c,
                     input logic bad, input logic [AW-1:0] badaddr);
    int            n;
    int            exp_n;
    int            exp_err;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] ai;
    corrupt_en = bad;
    bad_addr   = badaddr;
    exp_err    = 0;
    exp_first  = '0;
    for (int i = 0; i < int'(c); i++) begin
      ai = b + AW'(i);
      wq.push_back('{a: ai, d: s + DW'(i)});
`ifdef SRAM_SEQ_VERIFY_EN
      rq.push_back(ai);
      if (bad && ai == badaddr) begin
        if (exp_err == 0) exp_first = ai;
        exp_err++;
      end
`endif
    end
`ifdef SRAM_SEQ_VERIFY_EN
    exp_n = 12 * int'(c) + 2;
`else
    exp_n = 6 * int'(c) + 2;
`endif
    base_addr = b;
    seed      = s;
    count     = c;
    start     = 1'b1;
    step();
    start = 1'b0;
    n     = 1;
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("finished_cleared", 64'(finished), 64'(0));
    while (!finished && n < 400) begin
      step();
      n++;
    end
    chk("run_cycles", 64'(n), 64'(exp_n));
    chk("busy_at_finish", 64'(busy), 64'(0));
    chk("pass", 64'(pass), 64'(exp_err == 0));
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(exp_first));
    chk("wr_queue_drained", 64'(wq.size()), 64'(0));
    chk("rd_queue_drained", 64'(rq.size()), 64'(0));
    chk("idle_req", 64'({oen, wen}), 64'(2'b11));
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    seed      = '0;
    count     = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk_reset_outputs("idle");

    run(20'h00010, 32'h1000_0000, 4'd4, 1'b0, '0);
    run(20'h00010, 32'h1000_0000, 4'd4, 1'b1, 20'h00012);
    run(20'hFFFFE, 32'hFFFF_FFFF, 4'd3, 1'b0, '0);
    run(20'h00777, 32'h1234_5678, 4'd0, 1'b0, '0);

    // Reset during the third write, with an ignored start while busy.
    corrupt_en = 1'b0;
    nwrites    = 0;
    for (int i = 0; i < 4; i++) wq.push_back('{a: 20'h00100 + AW'(i), d: 32'h0000_00A5 + DW'(i)});
    base_addr = 20'h00100;
    seed      = 32'h0000_00A5;
    count     = 4'd4;
    start     = 1'b1;
    step();
    start = 1'b0;
    k     = 0;
    while (!(nwrites == 2 && !wen) && k < 200) begin
      step();
      k++;
    end
    chk("third_write_reached", 64'(k < 200), 64'(1));
    base_addr = 20'h55555;
    seed      = 32'hDEAD_BEEF;
    count     = 4'd1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("busy_ignored_start", 64'(busy), 64'(1));
    chk("addr_ignored_start", 64'(addr), 64'(20'h00102));
    chk("data_ignored_start", 64'(data_in), 64'(32'h0000_00A7));
    rst = 1'b1;
    step();
    step();
    chk_reset_outputs("midrun_rst");
    wq.delete();
    rq.delete();
    rst = 1'b0;
    step();
    run(20'h00200, 32'hCAFE_0000, 4'd2, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule
